// File: rtl/leta_quad_counter.sv
`default_nettype none
// ============================================================================
// Module   : leta_quad_counter
// Purpose  : Four-channel filtered quadrature counter with tear-free bus read.
// Revision : 1.0
// ============================================================================
module leta_quad_counter #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 8,
  parameter int FILTER_LEN = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ck_en,
  input  logic [NUM_CH-1:0] quad_a,
  input  logic [NUM_CH-1:0] quad_b,
  input  logic              cs_b,
  input  logic [1:0]        ad,
  input  logic              resoln,
  input  logic              test,
  output logic [CNT_W-1:0]  db_out,
  output logic              db_oe
);

  localparam int               RUN_W   = $clog2(FILTER_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FILTER_LEN);
  localparam logic [0:0]       ST_IDLE = 1'b0;
  localparam logic [0:0]       ST_HOLD = 1'b1;

  // Maps {A,B} onto its position in the forward cycle 00,01,11,10.
  function automatic logic [1:0] gray_pos(input logic [1:0] s);
    return {s[1], s[1] ^ s[0]};
  endfunction

  logic [NUM_CH-1:0]            a_s1_q, a_s2_q, b_s1_q, b_s2_q;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_all;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_s1_q <= '0;
      a_s2_q <= '0;
      b_s1_q <= '0;
      b_s2_q <= '0;
    end else begin
      a_s1_q <= quad_a;
      a_s2_q <= a_s1_q;
      b_s1_q <= quad_b;
      b_s2_q <= b_s1_q;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]       cur, step, samp_q, samp_d, acc_q, acc_d;
    logic [RUN_W-1:0] run_q, run_d, run_next;
    logic             prev_valid_q, prev_valid_d, accept;
    logic [CNT_W-1:0] cnt_q, cnt_d, delta;

    always_comb begin
      cur      = {a_s2_q[i], b_s2_q[i]};
      run_next = (cur != samp_q) ? RUN_W'(1) :
                 (run_q == RUN_MAX) ? RUN_MAX : run_q + 1'b1;
      accept   = (run_next == RUN_MAX) && (!prev_valid_q || (cur != acc_q));
      step     = gray_pos(cur) - gray_pos(acc_q);

      delta = '0;
      if (resoln) begin
        if (step == 2'd1)      delta = CNT_W'(1);
        else if (step == 2'd3) delta = '1;
      end else begin
        if (acc_q == 2'b10 && cur == 2'b00)      delta = CNT_W'(1);
        else if (acc_q == 2'b01 && cur == 2'b00) delta = '1;
      end

      samp_d       = samp_q;
      run_d        = run_q;
      acc_d        = acc_q;
      prev_valid_d = prev_valid_q;
      cnt_d        = cnt_q;
      if (ck_en && test) begin
        // Dropping prev_valid makes the state seen after self-test an adoption, not a count.
        cnt_d        = cnt_q + CNT_W'(1);
        prev_valid_d = 1'b0;
      end else if (ck_en) begin
        samp_d = cur;
        run_d  = run_next;
        if (accept) begin
          acc_d        = cur;
          prev_valid_d = 1'b1;
          if (prev_valid_q) cnt_d = cnt_q + delta;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        samp_q       <= '0;
        run_q        <= '0;
        acc_q        <= '0;
        prev_valid_q <= 1'b0;
        cnt_q        <= '0;
      end else begin
        samp_q       <= samp_d;
        run_q        <= run_d;
        acc_q        <= acc_d;
        prev_valid_q <= prev_valid_d;
        cnt_q        <= cnt_d;
      end
    end

    assign cnt_all[i] = cnt_q;
  end

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] rd_q, rd_d, rd_sel;

  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(ad) == k) rd_sel = cnt_all[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    case (state_q)
      ST_IDLE: begin
        if (!cs_b) begin
          rd_d    = rd_sel;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cs_b) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    db_oe  = (state_q == ST_HOLD);
    db_out = (state_q == ST_HOLD) ? rd_q : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_leta_quad_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_leta_quad_counter
// Purpose  : Scoreboard bench for the quadrature counter and its read port.
// Revision : 1.0
// ============================================================================
module tb_leta_quad_counter;

  logic       clk = 1'b0, rst = 1'b1, ck_en = 1'b0, cs_b = 1'b1;
  logic       resoln = 1'b0, test = 1'b0;
  logic [3:0] quad_a = '0, quad_b = '0;
  logic [1:0] ad = '0;
  logic [7:0] db_out;
  logic       db_oe;

  int         checks = 0, errors = 0;
  logic [7:0] sb_exp[$];
  int         sb_ch[$];
  logic       oe_prev = 1'b0;
  logic [7:0] mon_exp;
  int         mon_ch;

  leta_quad_counter #(.NUM_CH(4), .CNT_W(8), .FILTER_LEN(3)) dut (
    .clk(clk), .rst(rst), .ck_en(ck_en), .quad_a(quad_a), .quad_b(quad_b),
    .cs_b(cs_b), .ad(ad), .resoln(resoln), .test(test),
    .db_out(db_out), .db_oe(db_oe)
  );

  always #5 clk = ~clk;

  // Each rising db_oe retires the oldest expected read.
  always @(negedge clk) begin
    if (db_oe && !oe_prev) begin
      checks++;
      if (sb_exp.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected: db_oe rose with nothing pending, db_out=%h", db_out);
      end else begin
        mon_exp = sb_exp.pop_front();
        mon_ch  = sb_ch.pop_front();
        if (db_out !== mon_exp) begin
          errors++;
          $display("FAIL read_data ch%0d: got %h expected %h", mon_ch, db_out, mon_exp);
        end
      end
    end
    oe_prev = db_oe;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic strobe(input int n);
    repeat (n) begin
      ck_en = 1'b1;
      @(negedge clk);
      ck_en = 1'b0;
      @(negedge clk);
    end
  endtask

  // Apply a new {A,B} to one channel, let it clear the synchronizer, then sample n times.
  task automatic step(input int ch, input logic [1:0] ab, input int n);
    @(negedge clk);
    quad_a[ch] = ab[1];
    quad_b[ch] = ab[0];
    repeat (3) @(negedge clk);
    strobe(n);
  endtask

  task automatic read_ch(input int ch, input logic [7:0] exp_val);
    int n;
    sb_exp.push_back(exp_val);
    sb_ch.push_back(ch);
    @(negedge clk);
    cs_b = 1'b0;
    ad   = ch[1:0];
    n    = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!db_oe && n < 6);
    if (!db_oe) begin
      checks++;
      errors++;
      $display("FAIL read_timeout ch%0d: db_oe=%b expected 1", ch, db_oe);
      void'(sb_exp.pop_front());
      void'(sb_ch.pop_front());
    end
    cs_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (db_oe !== 1'b0) begin
      errors++;
      $display("FAIL reset_oe: got %b expected 0", db_oe);
    end
    checks++;
    if (db_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_out: got %h expected 00", db_out);
    end
    rst = 1'b0;
    strobe(3);
    for (int c = 0; c < 4; c++) read_ch(c, 8'h00);
  endtask

  task automatic test_4x;
    resoln = 1'b1;
    step(0, 2'b01, 4);
    read_ch(0, 8'h01);
    step(0, 2'b11, 4);
    step(0, 2'b10, 4);
    step(0, 2'b00, 4);
    read_ch(0, 8'h04);
    step(0, 2'b10, 4);
    step(0, 2'b11, 4);
    step(0, 2'b01, 4);
    step(0, 2'b00, 4);
    read_ch(0, 8'h00);
  endtask

  task automatic test_1x;
    resoln = 1'b0;
    step(2, 2'b01, 4);
    step(2, 2'b11, 4);
    step(2, 2'b10, 4);
    read_ch(2, 8'h00);
    step(2, 2'b00, 4);
    read_ch(2, 8'h01);
    for (int r = 0; r < 2; r++) begin
      step(2, 2'b10, 4);
      step(2, 2'b11, 4);
      step(2, 2'b01, 4);
      step(2, 2'b00, 4);
      read_ch(2, (r == 0) ? 8'h00 : 8'hFF);
    end
  endtask

  task automatic test_glitch;
    resoln = 1'b0;
    step(1, 2'b10, 2);
    step(1, 2'b00, 3);
    read_ch(1, 8'h00);
    step(1, 2'b10, 3);
    step(1, 2'b00, 3);
    read_ch(1, 8'h01);
  endtask

  task automatic test_illegal;
    resoln = 1'b1;
    step(3, 2'b11, 4);
    read_ch(3, 8'h00);
    step(3, 2'b10, 4);
    read_ch(3, 8'h01);
  endtask

  task automatic test_snapshot;
    resoln = 1'b1;
    step(1, 2'b01, 4);
    step(1, 2'b11, 4);
    step(1, 2'b10, 4);
    step(1, 2'b00, 4);
    step(1, 2'b01, 4);
    step(1, 2'b11, 4);
    @(negedge clk);
    quad_a[1] = 1'b1;
    quad_b[1] = 1'b0;
    repeat (3) @(negedge clk);
    strobe(2);
    // Third sample accepts 10 in the very cycle the read is requested.
    sb_exp.push_back(8'h07);
    sb_ch.push_back(1);
    ck_en = 1'b1;
    cs_b  = 1'b0;
    ad    = 2'd1;
    @(negedge clk);
    ck_en = 1'b0;
    checks++;
    if (db_oe !== 1'b1) begin
      errors++;
      $display("FAIL snap_latency: db_oe=%b expected 1", db_oe);
    end
    ad = 2'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (db_out !== 8'h07 || db_oe !== 1'b1) begin
      errors++;
      $display("FAIL hold_ignores_ad: db_out=%h db_oe=%b expected 07/1", db_out, db_oe);
    end
    cs_b = 1'b1;
    @(negedge clk);
    checks++;
    if (db_oe !== 1'b0) begin
      errors++;
      $display("FAIL oe_release: db_oe=%b expected 0", db_oe);
    end
    read_ch(1, 8'h08);
  endtask

  task automatic test_selftest_and_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    test = 1'b1;
    strobe(5);
    test = 1'b0;
    for (int c = 0; c < 4; c++) read_ch(c, 8'h05);
    sb_exp.push_back(8'h05);
    sb_ch.push_back(0);
    cs_b = 1'b0;
    ad   = 2'd0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (db_oe !== 1'b0 || db_out !== 8'h00) begin
      errors++;
      $display("FAIL rst_in_hold: db_oe=%b db_out=%h expected 0/00", db_oe, db_out);
    end
    rst  = 1'b0;
    cs_b = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 4; c++) read_ch(c, 8'h00);
  endtask

  initial begin
    test_reset();
    test_4x();
    test_1x();
    test_glitch();
    test_illegal();
    test_snapshot();
    test_selftest_and_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (sb_exp.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d reads pending, expected 0", sb_exp.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
